// File: rtl/max1271_resp_pkg.sv
// Shared constants for the MAX1271 slave emulator: state codes, frame sizes
// and control-byte field positions.
package max1271_resp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HUNT = 3'd1,
    ST_CTRL = 3'd2,
    ST_ACQ  = 3'd3,
    ST_DATA = 3'd4,
    ST_TAIL = 3'd5
  } state_t;

  localparam int unsigned CTRL_BITS = 8;
  localparam int unsigned DATA_BITS = 12;

  localparam int unsigned START_POS = 7;
  localparam int unsigned SEL_HI    = 6;
  localparam int unsigned SEL_LO    = 4;
  localparam int unsigned RNG_POS   = 3;
  localparam int unsigned BIP_POS   = 2;
  localparam int unsigned PD_HI     = 1;
  localparam int unsigned PD_LO     = 0;

  // Bipolar mode turns offset binary into two's complement by flipping the MSB.
  function automatic logic [11:0] code_result(input logic [11:0] v, input logic bip);
    return bip ? {~v[11], v[10:0]} : v;
  endfunction

endpackage

// File: rtl/max1271_resp_pin_sync_edge.sv
// Multi-flop synchronizer for one pin, with rise/fall pulses on the
// synchronized level.
module pin_sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic FASTCLK,
  input  logic clr_cmax,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  always_ff @(posedge FASTCLK or posedge clr_cmax) begin
    if (clr_cmax) begin
      chain <= {STAGES{RST_VAL}};
      prev  <= RST_VAL;
    end else begin
      chain <= {chain[STAGES-2:0], pin};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/max1271_resp.sv
// MAX1271 serial-ADC slave emulator: decodes the control byte from the
// monitor master and shifts back a 12-bit value taken from CH_VALUE.
module max1271_resp
  import max1271_resp_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TAIL_ZEROS  = 4
) (
  input  logic        FASTCLK,
  input  logic        clr_cmax,
  input  logic        ADC_CS_B,
  input  logic        ADC_SCLK,
  input  logic        ADC_DIN,
  input  logic [95:0] CH_VALUE,
  output logic        DOUT,
  output logic        DOUT_OE,
  output logic [7:0]  CTRL_BYTE,
  output logic        CTRL_VALID,
  output logic [15:0] CONV_CNT,
  output logic [2:0]  STATE
);

  localparam logic [4:0] CTRL_LAST = 5'(CTRL_BITS - 1);
  localparam logic [4:0] DATA_LAST = 5'(DATA_BITS - 1);
  localparam logic [4:0] TAIL_LAST = 5'(TAIL_ZEROS - 1);

  logic cs_lvl, cs_rise, cs_fall;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic din_lvl, din_rise, din_fall;

  pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
    .FASTCLK(FASTCLK), .clr_cmax(clr_cmax), .pin(ADC_CS_B),
    .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );
  pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .FASTCLK(FASTCLK), .clr_cmax(clr_cmax), .pin(ADC_SCLK),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  pin_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
    .FASTCLK(FASTCLK), .clr_cmax(clr_cmax), .pin(ADC_DIN),
    .level(din_lvl), .rise(din_rise), .fall(din_fall)
  );

  logic unused_edges;
  assign unused_edges = ^{cs_rise, cs_fall, sclk_lvl, din_rise, din_fall};

  state_t      state, state_n;
  logic [6:0]  shift, shift_n;
  logic [4:0]  cnt, cnt_n;
  logic [11:0] hold, hold_n;
  logic        dout, dout_n;
  logic [7:0]  ctrl_byte, ctrl_byte_n;
  logic        ctrl_valid_n, ctrl_valid;
  logic [15:0] conv_cnt, conv_cnt_n;

  logic [7:0]  byte_full;
  logic [11:0] ch_sel;
  logic [11:0] result;
  logic [3:0]  bit_idx;

  assign byte_full = {shift, din_lvl};
  assign result    = code_result(hold, ctrl_byte[BIP_POS]);
  assign bit_idx   = 4'(DATA_BITS - 1) - cnt[3:0];

  always_comb begin
    ch_sel = '0;
    for (int unsigned n = 0; n < 8; n++) begin
      if (byte_full[SEL_HI:SEL_LO] == 3'(n)) ch_sel = CH_VALUE[n*12 +: 12];
    end
  end

  always_comb begin
    state_n      = state;
    shift_n      = shift;
    cnt_n        = cnt;
    hold_n       = hold;
    dout_n       = dout;
    ctrl_byte_n  = ctrl_byte;
    ctrl_valid_n = 1'b0;
    conv_cnt_n   = conv_cnt;

    // Chip-select high overrides everything: drop any partial frame.
    if (cs_lvl) begin
      state_n = ST_IDLE;
      shift_n = '0;
      cnt_n   = '0;
      dout_n  = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: state_n = ST_HUNT;
        ST_HUNT: begin
          if (sclk_rise && din_lvl) begin
            shift_n = 7'd1;
            cnt_n   = 5'd1;
            state_n = ST_CTRL;
          end
        end
        ST_CTRL: begin
          if (sclk_rise) begin
            shift_n = byte_full[6:0];
            cnt_n   = cnt + 5'd1;
            if (cnt == CTRL_LAST) begin
              ctrl_byte_n  = byte_full;
              ctrl_valid_n = 1'b1;
              hold_n       = ch_sel;
              cnt_n        = '0;
              state_n      = (byte_full[PD_HI:PD_LO] == 2'b00) ? ST_HUNT : ST_ACQ;
            end
          end
        end
        ST_ACQ: begin
          if (sclk_fall) begin
            dout_n  = 1'b0;
            cnt_n   = '0;
            state_n = ST_DATA;
          end
        end
        ST_DATA: begin
          if (sclk_fall) begin
            dout_n = result[bit_idx];
            cnt_n  = cnt + 5'd1;
            if (cnt == DATA_LAST) begin
              conv_cnt_n = conv_cnt + 16'd1;
              cnt_n      = '0;
              state_n    = (TAIL_ZEROS == 0) ? ST_HUNT : ST_TAIL;
            end
          end
        end
        ST_TAIL: begin
          if (sclk_fall) begin
            dout_n = 1'b0;
            cnt_n  = cnt + 5'd1;
            if (cnt == TAIL_LAST) begin
              cnt_n   = '0;
              state_n = ST_HUNT;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge FASTCLK or posedge clr_cmax) begin
    if (clr_cmax) begin
      state      <= ST_IDLE;
      shift      <= '0;
      cnt        <= '0;
      hold       <= '0;
      dout       <= 1'b0;
      ctrl_byte  <= '0;
      ctrl_valid <= 1'b0;
      conv_cnt   <= '0;
    end else begin
      state      <= state_n;
      shift      <= shift_n;
      cnt        <= cnt_n;
      hold       <= hold_n;
      dout       <= dout_n;
      ctrl_byte  <= ctrl_byte_n;
      ctrl_valid <= ctrl_valid_n;
      conv_cnt   <= conv_cnt_n;
    end
  end

  assign DOUT       = dout;
  assign DOUT_OE    = (state != ST_IDLE);
  assign CTRL_BYTE  = ctrl_byte;
  assign CTRL_VALID = ctrl_valid;
  assign CONV_CNT   = conv_cnt;
  assign STATE      = state;

endmodule

// File: tb/tb_max1271_resp.sv
// Scoreboard bench for max1271_resp: the master driver queues expected DOUT
// bits and control bytes; monitors compare them as the DUT presents them.
module tb_max1271_resp;

  localparam int SS = 2;

  logic        FASTCLK = 1'b0;
  logic        clr_cmax;
  logic        ADC_CS_B;
  logic        ADC_SCLK;
  logic        ADC_DIN;
  logic [95:0] CH_VALUE;
  logic        DOUT;
  logic        DOUT_OE;
  logic [7:0]  CTRL_BYTE;
  logic        CTRL_VALID;
  logic [15:0] CONV_CNT;
  logic [2:0]  STATE;

  max1271_resp #(.SYNC_STAGES(SS), .TAIL_ZEROS(4)) dut (
    .FASTCLK(FASTCLK), .clr_cmax(clr_cmax), .ADC_CS_B(ADC_CS_B),
    .ADC_SCLK(ADC_SCLK), .ADC_DIN(ADC_DIN), .CH_VALUE(CH_VALUE),
    .DOUT(DOUT), .DOUT_OE(DOUT_OE), .CTRL_BYTE(CTRL_BYTE),
    .CTRL_VALID(CTRL_VALID), .CONV_CNT(CONV_CNT), .STATE(STATE)
  );

  always #5 FASTCLK = ~FASTCLK;

  int total = 0;
  int bad   = 0;

  logic       exp_dout_q[$];
  logic [7:0] exp_ctrl_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // DOUT monitor: the master samples DOUT on every SCLK rise.
  initial begin
    forever begin
      @(posedge ADC_SCLK);
      if (exp_dout_q.size() == 0) check("dout_unexpected_rise", 32'd1, 32'd0);
      else check("dout_bit", {31'd0, DOUT}, {31'd0, exp_dout_q.pop_front()});
      check("dout_oe_at_rise", {31'd0, DOUT_OE}, 32'd1);
    end
  end

  // Control-byte monitor: one queued byte per CTRL_VALID cycle.
  initial begin
    forever begin
      @(negedge FASTCLK);
      if (CTRL_VALID) begin
        if (exp_ctrl_q.size() == 0) check("ctrl_valid_unexpected", 32'd1, 32'd0);
        else check("ctrl_byte", {24'd0, CTRL_BYTE}, {24'd0, exp_ctrl_q.pop_front()});
      end
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge FASTCLK);
  endtask

  task automatic clk_bit(input logic d, input logic e);
    ADC_DIN = d;
    cycles(3);
    exp_dout_q.push_back(e);
    ADC_SCLK = 1'b1;
    cycles(6);
    ADC_SCLK = 1'b0;
    cycles(3);
  endtask

  task automatic set_ch(input int n, input logic [11:0] v);
    CH_VALUE[n*12 +: 12] = v;
  endtask

  // One frame: control byte, then nread read clocks (null, D11..D0, 4 zeros).
  // DIN is held high through ACQ/DATA/TAIL when din_fill is set.
  task automatic xfer(input logic [7:0] b, input logic [11:0] res, input bit mutate,
                      input int nread, input bit din_fill);
    logic [95:0] saved;
    logic        e;
    exp_ctrl_q.push_back(b);
    for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0);
    saved = CH_VALUE;
    if (mutate) CH_VALUE = ~CH_VALUE;
    for (int i = 0; i < nread; i++) begin
      if (i >= 1 && i <= 12) e = res[12-i];
      else e = 1'b0;
      clk_bit(din_fill && (i < 16), e);
    end
    CH_VALUE = saved;
  endtask

  initial begin
    clr_cmax = 1'b1;
    ADC_CS_B = 1'b1;
    ADC_SCLK = 1'b0;
    ADC_DIN  = 1'b0;
    CH_VALUE = '0;
    set_ch(0, 12'h3C5);
    set_ch(1, 12'h456);
    set_ch(3, 12'hA5C);
    set_ch(4, 12'h7E1);
    set_ch(7, 12'h800);
    #2;
    check("rst_dout", {31'd0, DOUT}, 32'd0);
    check("rst_dout_oe", {31'd0, DOUT_OE}, 32'd0);
    check("rst_ctrl_byte", {24'd0, CTRL_BYTE}, 32'h00);
    check("rst_ctrl_valid", {31'd0, CTRL_VALID}, 32'd0);
    check("rst_conv_cnt", {16'd0, CONV_CNT}, 32'd0);
    check("rst_state", {29'd0, STATE}, 32'd0);
    cycles(3);
    clr_cmax = 1'b0;
    cycles(4);
    check("idle_state", {29'd0, STATE}, 32'd0);

    // DOUT_OE rises SS+1 cycles after CS falls
    ADC_CS_B = 1'b0;
    cycles(SS);
    check("oe_before_latency", {31'd0, DOUT_OE}, 32'd0);
    cycles(1);
    check("oe_after_latency", {31'd0, DOUT_OE}, 32'd1);
    check("hunt_state", {29'd0, STATE}, 32'd1);
    cycles(2);

    // 8F: ch0=3C5, BIP=1 -> BC5; BF: ch3=A5C, BIP=1 -> 25C (CS stays low)
    xfer(8'h8F, 12'hBC5, 1'b0, 17, 1'b1);
    xfer(8'hBF, 12'h25C, 1'b0, 17, 1'b1);
    check("conv_cnt_2", {16'd0, CONV_CNT}, 32'd2);

    // BB (BIP=0) -> 123, BF (BIP=1) -> 923; CH_VALUE changes after capture
    set_ch(3, 12'h123);
    xfer(8'hBB, 12'h123, 1'b0, 17, 1'b1);
    xfer(8'hBF, 12'h923, 1'b1, 17, 1'b1);
    check("conv_cnt_4", {16'd0, CONV_CNT}, 32'd4);

    // three leading zeros then CF: ch4=7E1, BIP=1 -> FE1
    for (int i = 0; i < 3; i++) clk_bit(1'b0, 1'b0);
    xfer(8'hCF, 12'hFE1, 1'b0, 17, 1'b1);
    check("conv_cnt_5", {16'd0, CONV_CNT}, 32'd5);

    // abort after null + 6 data bits
    xfer(8'hBB, 12'h123, 1'b0, 7, 1'b1);
    ADC_CS_B = 1'b1;
    cycles(SS);
    check("oe_hold_after_cs_rise", {31'd0, DOUT_OE}, 32'd1);
    cycles(1);
    check("abort_oe", {31'd0, DOUT_OE}, 32'd0);
    check("abort_state", {29'd0, STATE}, 32'd0);
    check("abort_dout", {31'd0, DOUT}, 32'd0);
    check("abort_conv_cnt", {16'd0, CONV_CNT}, 32'd5);
    check("abort_ctrl_byte", {24'd0, CTRL_BYTE}, 32'hBB);
    ADC_CS_B = 1'b0;
    cycles(5);
    xfer(8'hBB, 12'h123, 1'b0, 17, 1'b1);
    check("conv_cnt_6", {16'd0, CONV_CNT}, 32'd6);

    // power-down byte: latched, no data, no count
    xfer(8'h8C, 12'h000, 1'b0, 17, 1'b0);
    check("pd_ctrl_byte", {24'd0, CTRL_BYTE}, 32'h8C);
    check("pd_conv_cnt", {16'd0, CONV_CNT}, 32'd6);
    check("pd_state", {29'd0, STATE}, 32'd1);

    // reset pulse in the middle of a control byte
    clk_bit(1'b1, 1'b0);
    clk_bit(1'b0, 1'b0);
    clk_bit(1'b1, 1'b0);
    check("mid_ctrl_state", {29'd0, STATE}, 32'd2);
    clr_cmax = 1'b1;
    #1;
    check("clr_state", {29'd0, STATE}, 32'd0);
    check("clr_ctrl_byte", {24'd0, CTRL_BYTE}, 32'h00);
    check("clr_conv_cnt", {16'd0, CONV_CNT}, 32'd0);
    check("clr_dout_oe", {31'd0, DOUT_OE}, 32'd0);
    check("clr_dout", {31'd0, DOUT}, 32'd0);
    check("clr_ctrl_valid", {31'd0, CTRL_VALID}, 32'd0);
    cycles(2);
    clr_cmax = 1'b0;
    cycles(SS + 3);
    check("resume_hunt", {29'd0, STATE}, 32'd1);
    // 9B: ch1=456, BIP=0 -> 456
    xfer(8'h9B, 12'h456, 1'b0, 17, 1'b1);
    check("conv_cnt_after_clr", {16'd0, CONV_CNT}, 32'd1);

    // counter wrap; FF selects ch7=800 with BIP=1 -> 000
    @(negedge FASTCLK);
    force dut.conv_cnt = 16'hFFFF;
    @(negedge FASTCLK);
    release dut.conv_cnt;
    cycles(2);
    check("conv_cnt_preset", {16'd0, CONV_CNT}, 32'hFFFF);
    xfer(8'hFF, 12'h000, 1'b0, 17, 1'b1);
    check("conv_cnt_wrap", {16'd0, CONV_CNT}, 32'd0);

    cycles(20);
    check("dout_queue_drained", exp_dout_q.size(), 32'd0);
    check("ctrl_queue_drained", exp_ctrl_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
